// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the radix-2 DIT FFT stage controller
// and its address generator.
package fft_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_LOG2N = 3;
  localparam int STAGE_W   = 4;

  // FP4 complex sample packing: real half in the upper nibble
  localparam int FP4_RE_MSB = 7;
  localparam int FP4_RE_LSB = 4;
  localparam int FP4_IM_MSB = 3;
  localparam int FP4_IM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } fft_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> operand pair and
// twiddle index for an in-place radix-2 DIT FFT.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int AW    = LOG2N,
  parameter int TW    = LOG2N - 1,
  parameter int KW    = LOG2N - 1
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [KW-1:0]      k,
  output logic [AW-1:0]      addr_a,
  output logic [AW-1:0]      addr_b,
  output logic [TW-1:0]      tw_addr
);

  logic [AW-1:0]      kk;
  logic [AW-1:0]      span;
  logic [AW-1:0]      pos;
  logic [AW-1:0]      grp;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    kk       = AW'(k);
    span     = AW'(1) << stage;
    pos      = kk & (span - AW'(1));
    grp      = kk >> stage;
    // groups are 2*span wide; the lower half holds input A of each pair
    addr_a   = (grp << (stage + STAGE_W'(1))) | pos;
    addr_b   = addr_a + span;
    tw_shift = STAGE_W'(LOG2N - 1) - stage;
    tw_addr  = TW'(pos << tw_shift);
  end

endmodule

// File: rtl/fft_stage_controller.sv
// Sequences an in-place radix-2 DIT FFT: per-butterfly read/twiddle addresses
// and one-cycle-delayed write-back addresses for a dual-port sample memory.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// RUN   | one butterfly read per cycle, k = 0 .. N/2-1
// GAP   | bubble so the last write of a stage lands before the next stage reads
// DONE  | one-cycle done pulse, then back to IDLE
module fft_stage_controller
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int AW    = LOG2N,
  parameter int TW    = LOG2N - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [3:0]    stage,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [TW-1:0] tw_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b
);

  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0]      K_LAST     = KW'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

  fft_state_t         state;
  logic [STAGE_W-1:0] stage_q;
  logic [KW-1:0]      k;
  logic [AW-1:0]      gen_a;
  logic [AW-1:0]      gen_b;
  logic [TW-1:0]      gen_tw;
  logic               run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      stage_q <= '0;
      k       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            stage_q <= '0;
            k       <= '0;
          end
        end
        ST_RUN: begin
          if (k == K_LAST) begin
            state <= ST_GAP;
            k     <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_GAP: begin
          if (stage_q == STAGE_LAST) begin
            state <= ST_DONE;
          end else begin
            stage_q <= stage_q + STAGE_W'(1);
            state   <= ST_RUN;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          stage_q <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          stage_q <= '0;
          k       <= '0;
        end
      endcase
    end
  end

  fft_addr_gen #(
    .LOG2N (LOG2N),
    .AW    (AW),
    .TW    (TW),
    .KW    (KW)
  ) u_addr_gen (
    .stage   (stage_q),
    .k       (k),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  // read side decodes only from registered state, so start never reaches it
  assign run       = (state == ST_RUN);
  assign rd_en     = run;
  assign rd_addr_a = run ? gen_a  : '0;
  assign rd_addr_b = run ? gen_b  : '0;
  assign tw_addr   = run ? gen_tw : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign stage     = stage_q;

  // write-back trails the read by the memory/ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      wr_en     <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
    end
  end

endmodule

// File: tb/tb_fft_stage_controller.sv
// Self-checking bench for fft_stage_controller: per-cycle trace against a
// pair-enumeration reference, plus an FP4 datapath model for an impulse FFT.
module tb_fft_stage_controller;
  import fft_pkg::*;

  localparam int N     = FFT_N;
  localparam int LOG2N = FFT_LOG2N;
  localparam int AW    = LOG2N;
  localparam int TW    = LOG2N - 1;
  localparam int L     = LOG2N * (N / 2 + 1) + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [3:0]    stage;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [TW-1:0] tw_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;

  int n_checks = 0;
  int n_err    = 0;

  int e_rd   [L];
  int e_a    [L];
  int e_b    [L];
  int e_tw   [L];
  int e_st   [L];
  int e_done [L];

  fft_stage_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference trace: stage s pairs every index i whose bit s is clear with
  // i + 2^s, in ascending i; twiddle exponent scales (i mod 2^s) to N/2 entries.
  task automatic build_expect();
    int c;
    int span;
    c = 0;
    for (int s = 0; s < LOG2N; s++) begin
      span = 1 << s;
      for (int i = 0; i < N; i++) begin
        if (((i / span) % 2) == 0) begin
          e_rd[c] = 1; e_a[c] = i; e_b[c] = i + span;
          e_tw[c] = (i % span) * (N / (2 * span));
          e_st[c] = s; e_done[c] = 0;
          c++;
        end
      end
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_st[c] = s; e_done[c] = 0;
      c++;
    end
    e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_st[c] = LOG2N - 1; e_done[c] = 1;
  endtask

  // FP4 datapath model: Q2.1 nibbles, memory/ROM with one-cycle read latency
  logic [7:0] mem    [N];
  logic [7:0] tw_rom [N/2];
  logic [7:0] lat_a, lat_b, lat_w, bx, by;
  int load_req  = 0;
  int load_seen = 0;

  function automatic int sx4(input logic [3:0] v);
    return {{28{v[3]}}, v};
  endfunction

  task automatic bfly(input logic [7:0] a, input logic [7:0] b, input logic [7:0] w,
                      output logic [7:0] x, output logic [7:0] y);
    int ar, ai, br, bi, wr, wi, pr, pi;
    ar = sx4(a[FP4_RE_MSB:FP4_RE_LSB]); ai = sx4(a[FP4_IM_MSB:FP4_IM_LSB]);
    br = sx4(b[FP4_RE_MSB:FP4_RE_LSB]); bi = sx4(b[FP4_IM_MSB:FP4_IM_LSB]);
    wr = sx4(w[FP4_RE_MSB:FP4_RE_LSB]); wi = sx4(w[FP4_IM_MSB:FP4_IM_LSB]);
    pr = (br * wr - bi * wi) >>> 1;
    pi = (br * wi + bi * wr) >>> 1;
    x = {4'(ar + pr), 4'(ai + pi)};
    y = {4'(ar - pr), 4'(ai - pi)};
  endtask

  always @(negedge clk) begin
    if (load_req != load_seen) begin
      for (int i = 0; i < N; i++) mem[i] = (i == 0) ? 8'h20 : 8'h00;
      tw_rom[0] = 8'h20; tw_rom[1] = 8'h1F; tw_rom[2] = 8'h0E; tw_rom[3] = 8'hFF;
      load_seen = load_req;
    end
    if (wr_en) begin
      bfly(lat_a, lat_b, lat_w, bx, by);
      mem[wr_addr_a] = bx;
      mem[wr_addr_b] = by;
    end
    if (rd_en) begin
      lat_a = mem[rd_addr_a];
      lat_b = mem[rd_addr_b];
      lat_w = tw_rom[tw_addr];
    end
  end

  // One full FFT; noisy mode toggles start while busy and holds it in DONE.
  task automatic run_fft(input bit noisy);
    int wcnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    wcnt = 0;
    for (int c = 0; c <= L; c++) begin
      #1;
      if (c == L || !noisy) start = 1'b0;
      else if ((c >= 2 && c <= 6) || c == L - 1) start = 1'b1;
      else start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c < L) begin
        chk($sformatf("c%0d_rd_en", c), rd_en, e_rd[c]);
        chk($sformatf("c%0d_rd_addr_a", c), rd_addr_a, e_a[c]);
        chk($sformatf("c%0d_rd_addr_b", c), rd_addr_b, e_b[c]);
        chk($sformatf("c%0d_tw_addr", c), tw_addr, e_tw[c]);
        chk($sformatf("c%0d_stage", c), stage, e_st[c]);
        chk($sformatf("c%0d_busy", c), busy, 1);
        chk($sformatf("c%0d_done", c), done, e_done[c]);
        chk($sformatf("c%0d_wr_en", c), wr_en, (c > 0) ? e_rd[c-1] : 0);
        chk($sformatf("c%0d_wr_addr_a", c), wr_addr_a, (c > 0) ? e_a[c-1] : 0);
        chk($sformatf("c%0d_wr_addr_b", c), wr_addr_b, (c > 0) ? e_b[c-1] : 0);
      end else begin
        chk("after_done_busy", busy, 0);
        chk("after_done_rd_en", rd_en, 0);
        chk("after_done_wr_en", wr_en, 0);
        chk("after_done_stage", stage, 0);
      end
      if (wr_en) wcnt++;
      @(posedge clk);
    end
    chk("wr_count", wcnt, LOG2N * N / 2);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr_a", rd_addr_a, 0);
    chk("rst_rd_addr_b", rd_addr_b, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr_a", wr_addr_a, 0);
    chk("rst_wr_addr_b", wr_addr_b, 0);

    build_expect();
    load_req++;
    repeat ($urandom_range(2, 6)) @(posedge clk);
    run_fft(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("impulse_mem%0d", i), mem[i], 8'h20);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 5)) @(posedge clk);
      run_fft(1'b1);
    end

    // reset in the middle of stage 1
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_abort_rd_en", rd_en, 1);
    chk("pre_abort_stage", stage, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_en", rd_en, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stage", stage, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("post_abort%0d_done", i), done, 0);
      chk($sformatf("post_abort%0d_rd_en", i), rd_en, 0);
      chk($sformatf("post_abort%0d_wr_en", i), wr_en, 0);
    end

    run_fft(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
